// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - song ROM walker that feeds DDS phase increments and sample strobes
module note_sequencer #(
    parameter int SAMPLE_DIV = 2083,
    parameter int SONG_AW    = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic               restart,
    input  logic               beat,
    output logic [SONG_AW-1:0] rom_addr,
    input  logic [11:0]        rom_data,
    output logic [5:0]         note_addr,
    input  logic [21:0]        note_k,
    output logic [21:0]        k,
    output logic               sampling_pulse,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_PLAY   = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam int              DW       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(SAMPLE_DIV - 1);

    logic [2:0]         state;
    logic [SONG_AW-1:0] pointer;
    logic [5:0]         note_reg;
    logic [5:0]         dur_reg;
    logic [5:0]         count;
    logic [DW-1:0]      div;
    logic               running;
    logic               qbeat;

    assign running  = play && ((state == S_PLAY) || (state == S_GAP));
    assign qbeat    = play && beat;
    assign rom_addr = pointer;
    // The frequency table is addressed straight from the ROM word in DECODE so its
    // answer is ready for LOAD one cycle later.
    assign note_addr = (state == S_DECODE) ? rom_data[11:6] : note_reg;
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            pointer        <= '0;
            note_reg       <= '0;
            dur_reg        <= '0;
            count          <= '0;
            div            <= '0;
            k              <= '0;
            sampling_pulse <= 1'b0;
        end else if (restart) begin
            state          <= S_FETCH;
            pointer        <= '0;
            count          <= '0;
            div            <= '0;
            k              <= '0;
            sampling_pulse <= 1'b0;
        end else begin
            sampling_pulse <= running && (div == DIV_LAST);
            if (running) begin
                div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (play) state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    note_reg <= rom_data[11:6];
                    dur_reg  <= rom_data[5:0];
                    state    <= (rom_data[5:0] == 6'd0) ? S_DONE : S_LOAD;
                end
                S_LOAD: begin
                    k     <= (note_reg == 6'd0) ? '0 : note_k;
                    count <= dur_reg;
                    state <= S_PLAY;
                end
                S_PLAY: begin
                    if (qbeat) begin
                        if (count == 6'd1) begin
                            count <= '0;
                            k     <= '0;
                            state <= S_GAP;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    // The last ROM entry ends the song rather than wrapping to 0.
                    if (qbeat) begin
                        if (pointer == '1) begin
                            state <= S_DONE;
                        end else begin
                            pointer <= pointer + 1'b1;
                            state   <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    k <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed vector bench for note_sequencer
module tb_note_sequencer;

    localparam int S = 2083;
    localparam logic [21:0] KA = 22'h0ABCD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic        restart = 1'b0;
    logic        beat = 1'b0;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data = '0;
    logic [5:0]  note_addr;
    logic [21:0] note_k = '0;
    logic [21:0] k;
    logic        sampling_pulse;
    logic        busy;
    logic        done;

    logic [11:0] rom [128];

    int checks = 0;
    int failures = 0;

    note_sequencer #(.SAMPLE_DIV(S), .SONG_AW(7)) dut (
        .clk(clk), .reset(reset), .play(play), .restart(restart), .beat(beat),
        .rom_addr(rom_addr), .rom_data(rom_data), .note_addr(note_addr),
        .note_k(note_k), .k(k), .sampling_pulse(sampling_pulse),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] ftab(input logic [5:0] n);
        ftab = (n == 6'd10) ? KA : {n, 16'h1234};
    endfunction

    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
        note_k   <= ftab(note_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic p, input logic b, input logic r);
        play = p;
        beat = b;
        restart = r;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        play;
        logic        beat;
        logic        restart;
        logic [21:0] k;
        logic [6:0]  addr;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vt[17];

    initial begin
        int pulses, since, bad, incs;
        logic prev_pulse, found, saw_top, back0;
        logic [6:0] prev_addr;

        for (int i = 0; i < 128; i++) rom[i] = '0;
        rom[0] = {6'd10, 6'd3};
        rom[1] = {6'd0, 6'd2};
        rom[2] = {6'd7, 6'd0};

        //         play beat rst  k     addr busy done
        vt[0]  = '{1'b1, 1'b0, 1'b0, 22'd0, 7'd0, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 22'd0, 7'd0, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 22'd0, 7'd0, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, KA,    7'd0, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, KA,    7'd0, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, KA,    7'd0, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, KA,    7'd0, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 22'd0, 7'd0, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 22'd0, 7'd1, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 22'd0, 7'd1, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 22'd0, 7'd1, 1'b1, 1'b0};
        vt[11] = '{1'b1, 1'b1, 1'b0, 22'd0, 7'd1, 1'b1, 1'b0};
        vt[12] = '{1'b1, 1'b1, 1'b0, 22'd0, 7'd1, 1'b1, 1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b0, 22'd0, 7'd1, 1'b1, 1'b0};
        vt[14] = '{1'b1, 1'b1, 1'b0, 22'd0, 7'd2, 1'b1, 1'b0};
        vt[15] = '{1'b1, 1'b0, 1'b0, 22'd0, 7'd2, 1'b1, 1'b0};
        vt[16] = '{1'b1, 1'b0, 1'b0, 22'd0, 7'd2, 1'b0, 1'b1};

        #1;
        chk("reset_k", k, 0);
        chk("reset_addr", rom_addr, 0);
        chk("reset_note_addr", note_addr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_pulse", sampling_pulse, 0);
        step(0, 0, 0);
        reset = 1'b0;
        step(0, 0, 0);
        chk("idle_no_play", busy, 0);

        for (int i = 0; i < 17; i++) begin
            if (i == 12) begin
                // rest note: k stays 0 while the sample strobe keeps running
                pulses = 0;
                bad = 0;
                for (int j = 0; j < S + 5; j++) begin
                    step(1, 0, 0);
                    if (sampling_pulse) pulses++;
                    if (k != 0) bad++;
                end
                chk("rest_pulses", pulses, 1);
                chk("rest_k_zero_steps", bad, 0);
            end
            step(vt[i].play, vt[i].beat, vt[i].restart);
            chk($sformatf("v%0d_k", i), k, vt[i].k);
            chk($sformatf("v%0d_addr", i), rom_addr, vt[i].addr);
            chk($sformatf("v%0d_busy", i), busy, vt[i].busy);
            chk($sformatf("v%0d_done", i), done, vt[i].done);
        end
        step(1, 1, 0);
        step(1, 1, 0);
        chk("done_hold", done, 1);
        chk("done_k", k, 0);

        // sample strobe spacing in a long note
        rom[0] = {6'd10, 6'd5};
        step(1, 0, 1);
        chk("restart_from_done_busy", busy, 1);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("long_note_k", k, KA);
        pulses = 0;
        bad = 0;
        since = 0;
        prev_pulse = 1'b0;
        for (int j = 0; j < 5 * S + 10; j++) begin
            step(1, 0, 0);
            since++;
            if (sampling_pulse) begin
                pulses++;
                if (since != S) bad++;
                if (prev_pulse) bad++;
                since = 0;
            end
            prev_pulse = sampling_pulse;
        end
        chk("pulse_count", pulses, 5);
        chk("pulse_spacing_errors", bad, 0);

        // pause mid-note with beats that must be ignored
        step(1, 1, 0);
        since++;
        bad = 0;
        pulses = 0;
        for (int j = 0; j < 10000; j++) begin
            step(0, (j % 2500) == 100, 0);
            if (sampling_pulse) pulses++;
            if (k != KA) bad++;
        end
        chk("pause_pulses", pulses, 0);
        chk("pause_k_changed_steps", bad, 0);
        found = 1'b0;
        for (int j = 0; j < 2 * S; j++) begin
            step(1, 0, 0);
            since++;
            if (sampling_pulse) begin
                found = 1'b1;
                break;
            end
        end
        chk("resume_pulse_seen", found, 1);
        chk("resume_spacing", since, S);
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        chk("resume_k_before_last_beat", k, KA);
        step(1, 1, 0);
        chk("resume_k_after_last_beat", k, 0);
        step(1, 1, 0);
        chk("resume_gap_addr", rom_addr, 1);

        // restart colliding with a beat while playing entry 5
        for (int i = 0; i < 5; i++) rom[i] = {6'd1, 6'd1};
        rom[5] = {6'd10, 6'd5};
        step(1, 0, 1);
        found = 1'b0;
        for (int j = 0; j < 500; j++) begin
            step(1, j[0], 0);
            if (rom_addr == 7'd5 && k == KA) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_addr5", found, 1);
        step(1, 1, 1);
        chk("restart_addr", rom_addr, 0);
        chk("restart_k", k, 0);
        chk("restart_busy", busy, 1);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("restart_entry0_k", k, ftab(6'd1));
        step(1, 0, 0);
        chk("restart_entry0_hold", k, ftab(6'd1));
        step(1, 1, 0);
        chk("restart_entry0_end", k, 0);

        // full ROM without an end marker
        for (int i = 0; i < 128; i++) rom[i] = {6'd2, 6'd1};
        step(1, 0, 1);
        prev_addr = rom_addr;
        incs = 0;
        bad = 0;
        saw_top = 1'b0;
        back0 = 1'b0;
        for (int j = 0; j < 3000; j++) begin
            step(1, 1, 0);
            if (rom_addr != prev_addr) begin
                if (rom_addr == prev_addr + 7'd1) incs++;
                else bad++;
            end
            if (rom_addr == 7'd127) saw_top = 1'b1;
            if (saw_top && rom_addr == 7'd0) back0 = 1'b1;
            prev_addr = rom_addr;
            if (done) break;
        end
        chk("full_done", done, 1);
        chk("full_busy", busy, 0);
        chk("full_last_addr", rom_addr, 127);
        chk("full_increments", incs, 127);
        chk("full_jumps", bad, 0);
        chk("full_no_wrap", back0, 0);
        for (int j = 0; j < 5; j++) step(1, 1, 0);
        chk("full_hold_addr", rom_addr, 127);
        chk("full_hold_done", done, 1);

        // asynchronous reset in the middle of a note
        step(1, 0, 1);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("pre_reset_k", k, ftab(6'd2));
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_k", k, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_done", done, 0);
        chk("async_reset_addr", rom_addr, 0);
        chk("async_reset_pulse", sampling_pulse, 0);
        play = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bad = 0;
        for (int j = 0; j < 3; j++) begin
            step(0, 1, 0);
            if (busy) bad++;
        end
        chk("post_reset_idle", bad, 0);
        step(1, 0, 0);
        chk("post_reset_fetch_busy", busy, 1);
        chk("post_reset_fetch_addr", rom_addr, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("post_reset_k", k, ftab(6'd2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 2083, clocks per sampling_pulse period (100 MHz / 48 kHz).
REQ-002 SHALL have parameter SONG_AW, default 7, song ROM address width (128 entries).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 play  input  1  level; 1 = run or continue, 0 = pause.
REQ-007 restart  input  1  single-cycle pulse; restart song from address 0.
REQ-008 beat  input  1  single-cycle tempo tick.
REQ-009 rom_addr  output  SONG_AW  song ROM address.
REQ-010 rom_data  input  12  song ROM word {note[11:6], dur[5:0]}, valid 1 cycle after rom_addr.
REQ-011 note_addr  output  6  frequency-table address.
REQ-012 note_k  input  22  phase increment from frequency table, valid 1 cycle after note_addr.
REQ-013 k  output  22  phase increment to the DDS.
REQ-014 sampling_pulse  output  1  single-cycle DDS sample strobe.
REQ-015 busy  output  1  high in FETCH, DECODE, LOAD, PLAY and GAP.
REQ-016 done  output  1  high in DONE.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, DECODE, LOAD, PLAY, GAP and DONE.
REQ-018 IDLE->FETCH when play=1; otherwise stay in IDLE.
REQ-019 FETCH SHALL drive rom_addr with the current pointer, then go to DECODE next cycle.
REQ-020 DECODE SHALL capture rom_data; if dur=0 (end marker) go to DONE, else drive note_addr=note and go to LOAD.
REQ-021 LOAD SHALL register k = (note=0 ? 0 : note_k) and duration counter = dur, then go to PLAY; k updates 3 cycles after FETCH entry.
REQ-022 PLAY SHALL decrement the counter on beat=1 with play=1; on the beat that takes the counter to 0, set k=0 and go to GAP.
REQ-023 GAP SHALL last exactly one qualified beat; on that beat increment the pointer and go to FETCH.
REQ-024 If the pointer is at 2^SONG_AW-1 when GAP ends, SHALL go to DONE instead of wrapping.
REQ-025 DONE SHALL hold k=0 and done=1 until restart.
REQ-026 restart=1 SHALL, from any state, clear pointer to 0, set k=0, clear the sample divider and enter FETCH next cycle; restart takes priority over all other events.
REQ-027 With play=0 in PLAY or GAP: counters, pointer and k SHALL hold, beats SHALL be ignored, and sampling_pulse SHALL be 0; on resume, continue from the held values.
REQ-028 play=0 in FETCH, DECODE or LOAD SHALL NOT stall; the FSM completes into PLAY and then pauses.
REQ-029 Sample divider SHALL count 0..SAMPLE_DIV-1 only in PLAY or GAP with play=1, and hold otherwise; sampling_pulse=1 for the one cycle where count=SAMPLE_DIV-1, then the count wraps to 0.
REQ-030 sampling_pulse SHALL be registered, never two consecutive cycles high.
REQ-031 A beat arriving in FETCH, DECODE or LOAD SHALL be dropped, not queued.

Reset
REQ-032 reset=1 SHALL immediately force: state IDLE, pointer 0, k=0, sampling_pulse=0, rom_addr=0, note_addr=0, busy=0, done=0, divider 0, duration counter 0.
REQ-033 Reset asserted mid-note SHALL abandon the note; after release, operation restarts from address 0 once play=1.

Verification
REQ-034 ROM[0]={note 10,dur 3}, note_k(10)=22'h0ABCD, play=1 -> k=22'h0ABCD three cycles after FETCH; k=0 after the 3rd beat; 1 GAP beat; rom_addr=1.
REQ-035 PLAY for 5*SAMPLE_DIV cycles with no beats -> exactly 5 sampling_pulse, spaced 2083 cycles apart.
REQ-036 play dropped for 10000 cycles mid-note, with 4 beats issued -> counter, k and divider unchanged, no sampling_pulse; resume completes the remaining duration.
REQ-037 ROM[1]={note 0,dur 2} -> k=0 for 2 beats, sampling_pulse still generated; ROM[2] dur=0 -> DONE, done=1, busy=0.
REQ-038 restart and beat on the same cycle while in PLAY at rom_addr=5 -> next cycle FETCH, rom_addr=0, k=0, beat ignored.
REQ-039 Full 128-entry ROM with no end marker -> DONE after entry 127's GAP; rom_addr never returns to 0 without restart.
